// File: rtl/alu_vec_if.sv
// Handshake and ALU-facing bus bundle for alu_vec_sequencer.
// Vectors are packed as [lane][bit] so that lane slicing matches the ALU.
interface alu_vec_if #(
  parameter int WIDTH = 4,
  parameter int n_alu = 4,
  parameter int SEL_W = 3
);
  logic                         cmd_valid, cmd_ready;
  logic [n_alu-1:0][WIDTH-1:0]  cmd_a, cmd_b;
  logic [SEL_W-1:0]             cmd_sel;

  logic [n_alu-1:0][WIDTH-1:0]  alu_a, alu_b, alu_out;
  logic [SEL_W-1:0]             alu_sel;
  logic [n_alu-1:0]             alu_carry, alu_gt, alu_eq, alu_lt;

  logic                         rsp_valid, rsp_ready, rsp_err;
  logic [n_alu-1:0][WIDTH-1:0]  rsp_data;
  logic [n_alu-1:0]             rsp_carry, rsp_gt, rsp_eq, rsp_lt;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel,
           alu_out, alu_carry, alu_gt, alu_eq, alu_lt, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel,
           rsp_valid, rsp_data, rsp_carry, rsp_gt, rsp_eq, rsp_lt, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_sel,
           alu_out, alu_carry, alu_gt, alu_eq, alu_lt, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel,
           rsp_valid, rsp_data, rsp_carry, rsp_gt, rsp_eq, rsp_lt, rsp_err
  );
endinterface

// File: rtl/alu_vec_sequencer.sv
// Single-outstanding command sequencer for the vectorial ALU: accept, wait
// ALU_LAT cycles, capture result and flags, hand back on the response port.
module alu_vec_sequencer #(
  parameter int WIDTH   = 4,
  parameter int n_alu   = 4,
  parameter int SEL_W   = 3,
  parameter int ALU_LAT = 1,
  parameter int OPC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_vec_if.master        io,
  output logic [OPC_W-1:0] op_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT = 4'(ALU_LAT);

  state_t           state, nxt;
  logic [3:0]       lat_cnt;
  logic [n_alu-1:0] lane_err;
  logic             accept, capture, retire;

  assign accept  = (state == S_IDLE) && io.cmd_valid && io.cmd_ready;
  assign capture = (state == S_WAIT) && (lat_cnt == 4'd0);
  assign retire  = (state == S_RESP) && io.rsp_ready;

  // Exactly one of gt/eq/lt must be set per lane; anything else is flagged.
  for (genvar g = 0; g < n_alu; g++) begin : g_lane
    assign lane_err[g] = ({1'b0, io.alu_gt[g]} + {1'b0, io.alu_eq[g]}
                        + {1'b0, io.alu_lt[g]}) != 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (accept)  nxt = S_WAIT;
      S_WAIT:  if (capture) nxt = S_RESP;
      S_RESP:  if (retire)  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so that cmd_ready
  // stays low through reset and rises one cycle after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io.cmd_ready <= 1'b0;
      io.rsp_valid <= 1'b0;
      io.alu_a     <= '0;
      io.alu_b     <= '0;
      io.alu_sel   <= '0;
      io.rsp_data  <= '0;
      io.rsp_carry <= '0;
      io.rsp_gt    <= '0;
      io.rsp_eq    <= '0;
      io.rsp_lt    <= '0;
      io.rsp_err   <= 1'b0;
      lat_cnt      <= '0;
      op_count     <= '0;
    end else begin
      io.cmd_ready <= (nxt == S_IDLE);
      io.rsp_valid <= (nxt == S_RESP);
      if (accept) begin
        io.alu_a   <= io.cmd_a;
        io.alu_b   <= io.cmd_b;
        io.alu_sel <= io.cmd_sel;
        lat_cnt    <= LAT;
      end else if (state == S_WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (capture) begin
        io.rsp_data  <= io.alu_out;
        io.rsp_carry <= io.alu_carry;
        io.rsp_gt    <= io.alu_gt;
        io.rsp_eq    <= io.alu_eq;
        io.rsp_lt    <= io.alu_lt;
        io.rsp_err   <= |lane_err;
      end
      if (retire) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_vec_sequencer.sv
// Bench for alu_vec_sequencer: three instances (ALU_LAT 1/4/0, OPC_W 16/16/3)
// share stimulus, each held in reset except the one under test.
module tb_alu_vec_sequencer;
  logic        clk = 1'b0;
  logic [2:0]  rst_v;
  logic        cmd_valid, rsp_ready;
  logic [15:0] cmd_a, cmd_b, alu_out;
  logic [2:0]  cmd_sel;
  logic [3:0]  alu_carry, alu_gt, alu_eq, alu_lt;

  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_vec_if #(.WIDTH(4), .n_alu(4), .SEL_W(3)) i0 ();
  alu_vec_if #(.WIDTH(4), .n_alu(4), .SEL_W(3)) i1 ();
  alu_vec_if #(.WIDTH(4), .n_alu(4), .SEL_W(3)) i2 ();

  alu_vec_sequencer #(.ALU_LAT(1), .OPC_W(16)) u0 (.clk(clk), .rst(rst_v[0]), .io(i0), .op_count(cnt0));
  alu_vec_sequencer #(.ALU_LAT(4), .OPC_W(16)) u1 (.clk(clk), .rst(rst_v[1]), .io(i1), .op_count(cnt1));
  alu_vec_sequencer #(.ALU_LAT(0), .OPC_W(3))  u2 (.clk(clk), .rst(rst_v[2]), .io(i2), .op_count(cnt2));

  assign i0.cmd_valid = cmd_valid; assign i1.cmd_valid = cmd_valid; assign i2.cmd_valid = cmd_valid;
  assign i0.cmd_a = cmd_a;         assign i1.cmd_a = cmd_a;         assign i2.cmd_a = cmd_a;
  assign i0.cmd_b = cmd_b;         assign i1.cmd_b = cmd_b;         assign i2.cmd_b = cmd_b;
  assign i0.cmd_sel = cmd_sel;     assign i1.cmd_sel = cmd_sel;     assign i2.cmd_sel = cmd_sel;
  assign i0.alu_out = alu_out;     assign i1.alu_out = alu_out;     assign i2.alu_out = alu_out;
  assign i0.alu_carry = alu_carry; assign i1.alu_carry = alu_carry; assign i2.alu_carry = alu_carry;
  assign i0.alu_gt = alu_gt;       assign i1.alu_gt = alu_gt;       assign i2.alu_gt = alu_gt;
  assign i0.alu_eq = alu_eq;       assign i1.alu_eq = alu_eq;       assign i2.alu_eq = alu_eq;
  assign i0.alu_lt = alu_lt;       assign i1.alu_lt = alu_lt;       assign i2.alu_lt = alu_lt;
  assign i0.rsp_ready = rsp_ready; assign i1.rsp_ready = rsp_ready; assign i2.rsp_ready = rsp_ready;

  // DUT outputs gathered per instance for the compare loop.
  logic [2:0]  d_ready, d_valid, d_err;
  logic [15:0] d_a[3], d_b[3], d_data[3], d_cnt[3];
  logic [2:0]  d_sel[3];
  logic [3:0]  d_carry[3], d_gt[3], d_eq[3], d_lt[3];

  assign d_ready = {i2.cmd_ready, i1.cmd_ready, i0.cmd_ready};
  assign d_valid = {i2.rsp_valid, i1.rsp_valid, i0.rsp_valid};
  assign d_err   = {i2.rsp_err,   i1.rsp_err,   i0.rsp_err};
  assign d_a[0] = i0.alu_a;  assign d_a[1] = i1.alu_a;  assign d_a[2] = i2.alu_a;
  assign d_b[0] = i0.alu_b;  assign d_b[1] = i1.alu_b;  assign d_b[2] = i2.alu_b;
  assign d_sel[0] = i0.alu_sel; assign d_sel[1] = i1.alu_sel; assign d_sel[2] = i2.alu_sel;
  assign d_data[0] = i0.rsp_data;   assign d_data[1] = i1.rsp_data;   assign d_data[2] = i2.rsp_data;
  assign d_carry[0] = i0.rsp_carry; assign d_carry[1] = i1.rsp_carry; assign d_carry[2] = i2.rsp_carry;
  assign d_gt[0] = i0.rsp_gt; assign d_gt[1] = i1.rsp_gt; assign d_gt[2] = i2.rsp_gt;
  assign d_eq[0] = i0.rsp_eq; assign d_eq[1] = i1.rsp_eq; assign d_eq[2] = i2.rsp_eq;
  assign d_lt[0] = i0.rsp_lt; assign d_lt[1] = i1.rsp_lt; assign d_lt[2] = i2.rsp_lt;
  assign d_cnt[0] = cnt0; assign d_cnt[1] = cnt1; assign d_cnt[2] = {13'd0, cnt2};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Transaction-level model: each instance is a timeline of
  // idle -> accepted -> result after LAT+1 edges -> held until rsp_ready.
  int          lat[3]  = '{1, 4, 0};
  logic [15:0] mask[3] = '{16'hFFFF, 16'hFFFF, 16'h0007};
  bit          m_ready[3], m_valid[3], m_err[3];
  int          m_cd[3];
  logic [15:0] m_a[3], m_b[3], m_data[3], m_cnt[3];
  logic [2:0]  m_sel[3];
  logic [3:0]  m_carry[3], m_gt[3], m_eq[3], m_lt[3];

  function automatic bit flags_bad(input logic [3:0] g, input logic [3:0] e, input logic [3:0] l);
    for (int i = 0; i < 4; i++)
      if (int'(g[i]) + int'(e[i]) + int'(l[i]) != 1) return 1'b1;
    return 1'b0;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_v[k]) begin
        m_ready[k] = 0; m_valid[k] = 0; m_err[k] = 0; m_cd[k] = -1;
        m_a[k] = 0; m_b[k] = 0; m_sel[k] = 0; m_data[k] = 0; m_cnt[k] = 0;
        m_carry[k] = 0; m_gt[k] = 0; m_eq[k] = 0; m_lt[k] = 0;
      end else if (m_valid[k]) begin
        if (rsp_ready) begin
          m_valid[k] = 0; m_ready[k] = 1;
          m_cnt[k] = (m_cnt[k] + 16'd1) & mask[k];
        end
      end else if (m_cd[k] > 0) begin
        m_cd[k]--;
        if (m_cd[k] == 0) begin
          m_data[k] = alu_out; m_carry[k] = alu_carry;
          m_gt[k] = alu_gt; m_eq[k] = alu_eq; m_lt[k] = alu_lt;
          m_err[k] = flags_bad(alu_gt, alu_eq, alu_lt);
          m_valid[k] = 1; m_cd[k] = -1;
        end
      end else if (m_ready[k] && cmd_valid) begin
        m_ready[k] = 0;
        m_a[k] = cmd_a; m_b[k] = cmd_b; m_sel[k] = cmd_sel;
        m_cd[k] = lat[k] + 1;
      end else begin
        m_ready[k] = 1;
      end
    end
  end

  // Per-cycle compare; a held reset forces every output to zero immediately.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bit live;
      live = rst_v[k];
      chk($sformatf("u%0d.cmd_ready", k), {15'd0, d_ready[k]}, live ? {15'd0, m_ready[k]} : 16'd0);
      chk($sformatf("u%0d.rsp_valid", k), {15'd0, d_valid[k]}, live ? {15'd0, m_valid[k]} : 16'd0);
      chk($sformatf("u%0d.rsp_err", k),   {15'd0, d_err[k]},   live ? {15'd0, m_err[k]}   : 16'd0);
      chk($sformatf("u%0d.op_count", k),  d_cnt[k],  live ? m_cnt[k]  : 16'd0);
      chk($sformatf("u%0d.alu_a", k),     d_a[k],    live ? m_a[k]    : 16'd0);
      chk($sformatf("u%0d.alu_b", k),     d_b[k],    live ? m_b[k]    : 16'd0);
      chk($sformatf("u%0d.alu_sel", k),   {13'd0, d_sel[k]}, live ? {13'd0, m_sel[k]} : 16'd0);
      chk($sformatf("u%0d.rsp_data", k),  d_data[k], live ? m_data[k] : 16'd0);
      chk($sformatf("u%0d.rsp_carry", k), {12'd0, d_carry[k]}, live ? {12'd0, m_carry[k]} : 16'd0);
      chk($sformatf("u%0d.rsp_gt", k),    {12'd0, d_gt[k]}, live ? {12'd0, m_gt[k]} : 16'd0);
      chk($sformatf("u%0d.rsp_eq", k),    {12'd0, d_eq[k]}, live ? {12'd0, m_eq[k]} : 16'd0);
      chk($sformatf("u%0d.rsp_lt", k),    {12'd0, d_lt[k]}, live ? {12'd0, m_lt[k]} : 16'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_alu(input logic [15:0] o, input logic [3:0] c, input logic [3:0] g,
                         input logic [3:0] e, input logic [3:0] l);
    alu_out = o; alu_carry = c; alu_gt = g; alu_eq = e; alu_lt = l;
  endtask

  // One full op on instance k, called while its cmd_ready is high.
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel,
                       input logic [15:0] o, input logic [3:0] c, input logic [3:0] g,
                       input logic [3:0] e, input logic [3:0] l,
                       input logic exp_err, input logic [15:0] exp_cnt);
    int n;
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_sel = sel;
    tick();
    cmd_valid = 0; cmd_a = ~a; cmd_b = ~b; cmd_sel = ~sel;
    set_alu(o, c, g, e, l);
    n = 0;
    while (!d_valid[k] && n < 30) begin tick(); n++; end
    @(negedge clk);
    chk($sformatf("op%0d.valid_seen", k), {15'd0, d_valid[k]}, 16'd1);
    chk($sformatf("op%0d.rsp_data", k),   d_data[k], o);
    chk($sformatf("op%0d.rsp_gt", k),     {12'd0, d_gt[k]}, {12'd0, g});
    chk($sformatf("op%0d.rsp_err", k),    {15'd0, d_err[k]}, {15'd0, exp_err});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    @(negedge clk);
    chk($sformatf("op%0d.op_count", k),  d_cnt[k], exp_cnt);
    chk($sformatf("op%0d.cmd_ready", k), {15'd0, d_ready[k]}, 16'd1);
  endtask

  initial begin
    rst_v = 3'b000; cmd_valid = 1; rsp_ready = 0;
    cmd_a = 16'hDEAD; cmd_b = 16'hBEEF; cmd_sel = 3'd7;
    set_alu(16'h0, 4'h0, 4'h0, 4'h0, 4'hF);

    // Reset held with a command offered
    repeat (2) tick();
    @(negedge clk);
    chk("rst.cmd_ready", {15'd0, d_ready[0]}, 16'd0);
    chk("rst.alu_a",     d_a[0], 16'd0);
    chk("rst.rsp_valid", {15'd0, d_valid[0]}, 16'd0);
    chk("rst.op_count",  d_cnt[0], 16'd0);
    rst_v[0] = 1; cmd_valid = 0;
    tick();
    @(negedge clk);
    chk("rst.ready_after_release", {15'd0, d_ready[0]}, 16'd1);

    // Single op, ALU_LAT=1: stub is only correct during cycle 2
    cmd_valid = 1; cmd_a = 16'h1234; cmd_b = 16'h4321; cmd_sel = 3'd1;
    set_alu(16'hAAAA, 4'hF, 4'hF, 4'h0, 4'h0);
    tick();
    cmd_valid = 0; cmd_a = 16'h0BAD;
    @(negedge clk);
    chk("single.alu_a",   d_a[0], 16'h1234);
    chk("single.alu_b",   d_b[0], 16'h4321);
    chk("single.alu_sel", {13'd0, d_sel[0]}, 16'd1);
    tick();
    set_alu(16'h5555, 4'b0010, 4'b0000, 4'b0000, 4'b1111);
    tick();
    set_alu(16'hAAAA, 4'hF, 4'hF, 4'h0, 4'h0);
    @(negedge clk);
    chk("single.rsp_valid", {15'd0, d_valid[0]}, 16'd1);
    chk("single.rsp_data",  d_data[0], 16'h5555);
    chk("single.rsp_carry", {12'd0, d_carry[0]}, 16'h0002);
    chk("single.rsp_lt",    {12'd0, d_lt[0]}, 16'h000F);
    chk("single.rsp_err",   {15'd0, d_err[0]}, 16'd0);

    // Backpressure: five cycles of rsp_ready=0
    repeat (5) tick();
    @(negedge clk);
    chk("bp.rsp_valid", {15'd0, d_valid[0]}, 16'd1);
    chk("bp.rsp_data",  d_data[0], 16'h5555);
    chk("bp.cmd_ready", {15'd0, d_ready[0]}, 16'd0);
    chk("bp.op_count",  d_cnt[0], 16'd0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    @(negedge clk);
    chk("bp.op_count_after", d_cnt[0], 16'd1);
    chk("bp.cmd_ready_after", {15'd0, d_ready[0]}, 16'd1);
    chk("bp.rsp_valid_after", {15'd0, d_valid[0]}, 16'd0);
    chk("bp.rsp_data_kept",   d_data[0], 16'h5555);

    // Flag errors: lane 2 double-set, then clean, then lane 3 with no flag
    do_op(0, 16'h0F0F, 16'h00FF, 3'd2, 16'h1234, 4'b0000, 4'b0100, 4'b0100, 4'b1011, 1'b1, 16'd2);
    do_op(0, 16'h2222, 16'h3333, 3'd3, 16'h9ABC, 4'b1001, 4'b0011, 4'b0100, 4'b1000, 1'b0, 16'd3);
    do_op(0, 16'h7777, 16'h0001, 3'd4, 16'hFFFF, 4'b1111, 4'b0000, 4'b0000, 4'b0111, 1'b1, 16'd4);

    // Reset during WAIT on the ALU_LAT=4 instance
    rst_v[0] = 0; rst_v[1] = 1;
    tick();
    cmd_valid = 1; cmd_a = 16'hCAFE; cmd_b = 16'hF00D; cmd_sel = 3'd5;
    tick();
    cmd_valid = 0;
    tick();
    tick();
    rst_v[1] = 0;
    @(negedge clk);
    chk("rstwait.rsp_valid", {15'd0, d_valid[1]}, 16'd0);
    chk("rstwait.alu_a",     d_a[1], 16'd0);
    chk("rstwait.op_count",  d_cnt[1], 16'd0);
    repeat (2) tick();
    rst_v[1] = 1;
    repeat (8) tick();
    @(negedge clk);
    chk("rstwait.no_rsp", {15'd0, d_valid[1]}, 16'd0);
    do_op(1, 16'h0102, 16'h0304, 3'd6, 16'h4242, 4'b0101, 4'b1000, 4'b0001, 4'b0110, 1'b0, 16'd1);

    // Back-to-back wrap on the OPC_W=3, ALU_LAT=0 instance
    rst_v[1] = 0; rst_v[2] = 1;
    tick();
    rsp_ready = 1;
    for (int i = 0; i < 9; i++) begin
      cmd_valid = 1;
      cmd_a = 16'h1111 * i[15:0]; cmd_b = ~cmd_a; cmd_sel = i[2:0];
      set_alu(16'h0101 * i[15:0], i[3:0], 4'b0001, 4'b0010, 4'b1100);
      repeat (3) tick();
      @(negedge clk);
      chk($sformatf("wrap.op_count_%0d", i), d_cnt[2], 16'((i + 1) % 8));
    end
    cmd_valid = 0; rsp_ready = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_vec_sequencer.md
Name: alu_vec_sequencer

Overview:
- Command-side initiator for ALU_VECTORIAL: accepts one vector operation on a valid/ready command port and drives a/b/select to the ALU.
- Waits the ALU pipeline latency, then captures data_out, carry_out and compare flags.
- Returns the captured result on a valid/ready response port.
- Sits between the datapath controller and the vectorial ALU.
- Lets the ALU be used from handshaked logic instead of free-running stimulus.

Parameters:
- WIDTH, 4, bits per ALU lane
- n_alu, 4, number of lanes; vector width VW = WIDTH*n_alu
- SEL_W, 3, width of ALU select code
- ALU_LAT, 1, ALU result latency in clk cycles after operands are presented (legal 0..15)
- OPC_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept command
- cmd_a  in  VW  operand vector A
- cmd_b  in  VW  operand vector B
- cmd_sel  in  SEL_W  ALU operation code
- alu_a  out  VW  to ALU a
- alu_b  out  VW  to ALU b
- alu_sel  out  SEL_W  to ALU select
- alu_out  in  VW  from ALU data_out
- alu_carry  in  n_alu  from ALU carry_out (per lane)
- alu_gt / alu_eq / alu_lt  in  n_alu each  from ALU a_greater/a_equal/a_less (per lane)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  VW  captured alu_out
- rsp_carry, rsp_gt, rsp_eq, rsp_lt  out  n_alu each  captured flags
- rsp_err  out  1  flag-consistency error for this result
- op_count  out  OPC_W  completed responses, wraps

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including cmd_ready; latency counter 0. cmd_ready rises in the first cycle after rst deasserts.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge E, alu_a/alu_b/alu_sel register cmd_a/cmd_b/cmd_sel and become visible in cycle T=E+1.
  - Latency counter loads ALU_LAT; state goes to WAIT.
  - Without a handshake, alu_* hold their last values.
- WAIT:
  - cmd_ready=0; alu_* held stable.
  - Capture of alu_out/flags occurs at the edge closing cycle T+ALU_LAT. ALU_LAT=0 captures at the end of cycle T, i.e. a combinational ALU.
  - State goes to RESP on the capture edge.
- RESP:
  - rsp_valid=1; all rsp_* stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: op_count increments, wrapping from all-ones to 0; state returns to IDLE; rsp_valid=0 next cycle.
  - cmd_ready stays 0 in RESP, so accept and response never overlap.
  - Best throughput is one operation per ALU_LAT+3 cycles.
- rsp_err:
  - Set at capture if, for any lane, gt+eq+lt != 1.
  - Data and flags are still returned unchanged.
  - Cleared at the next capture.
- rsp_* fields retain their values after the handshake until the next capture.
- Reset mid-operation (WAIT or RESP): the pending op is dropped and no response is produced. Outputs return to reset values immediately and op_count clears to 0.
- cmd_* changes while cmd_ready=0 are ignored.

Test Plan:
- Reset: hold rst=0 for 2 cycles with cmd_valid=1 -> cmd_ready=0, alu_a=0, rsp_valid=0, op_count=0 during reset; cmd_ready=1 in the first cycle after release.
- Single op (ALU_LAT=1): accept cmd_a=16'h1234, cmd_b=16'h4321, cmd_sel=3'd1 at edge 0 -> alu_a=16'h1234, alu_b=16'h4321, alu_sel=1 in cycle 1. Bench ALU stub drives alu_out=16'h5555, alu_carry=4'b0010, alu_lt=4'b1111, gt=eq=0 in cycle 2. Expect rsp_valid=1 in cycle 3 with rsp_data=16'h5555, rsp_carry=4'b0010, rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data constant, cmd_ready=0, op_count=0. Raise rsp_ready -> op_count=1 and cmd_ready=1 next cycle.
- Flag error: stub drives lane 2 with gt=1 and eq=1 (alu_gt=4'b0100, alu_eq=4'b0100, alu_lt=4'b1011) -> rsp_err=1, rsp_gt=4'b0100 returned. The next clean op gives rsp_err=0.
- Reset in WAIT (ALU_LAT=4): assert rst two cycles after accept -> no rsp_valid ever; op_count=0; after release, a new command completes normally.
- Counter wrap (OPC_W=3, ALU_LAT=0): complete 9 back-to-back ops with rsp_ready=1 -> op_count reads 1..7, 0, 1; each op spans 3 cycles.
